// File: rtl/dyna_cmd_sequencer.sv
// dyna_cmd_sequencer: takes one two-word Dynamixel instruction, programs the
// UART_Dynamixel register block, starts transmission, waits for TX done and,
// when asked for, the status reply, then hands both reply words back through a
// valid/ready response port with a status code.
// WAIT_TX and WAIT_RX are each bounded by TIMEOUT_CYCLES.
// Optional feature: define DYNA_RETRY_EN to re-run the whole load/start
// sequence up to RETRY_MAX times after a timeout before reporting it.
module dyna_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned RETRY_MAX      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_word0,
    input  logic [31:0] cmd_word1,
    input  logic        cmd_expect_reply,
    output logic [2:0]  dyn_rw_ad,
    output logic        dyn_write_en,
    output logic        dyn_read_en,
    output logic [31:0] dyn_write_data,
    input  logic [31:0] dyn_read_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data1,
    output logic [31:0] rsp_data2,
    output logic [1:0]  rsp_status,
    output logic        busy
);

    // UART_Dynamixel register map
    localparam logic [2:0] AddrRxStat = 3'b000;
    localparam logic [2:0] AddrData1  = 3'b001;
    localparam logic [2:0] AddrData2  = 3'b010;
    localparam logic [2:0] AddrTxCtl  = 3'b100;
    localparam logic [2:0] AddrWord0  = 3'b101;
    localparam logic [2:0] AddrWord1  = 3'b110;

    localparam logic [1:0] StatusOk      = 2'b00;
    localparam logic [1:0] StatusTxTmo   = 2'b01;
    localparam logic [1:0] StatusRxTmo   = 2'b10;
    localparam logic [1:0] StatusNoReply = 2'b11;

    // Last timer value allowed in a wait state before it counts as a timeout
    localparam logic [19:0] TimeoutLast = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StLoad0,
        StLoad1,
        StStart,
        StWaitTx,
        StClr,
        StWaitRx,
        StCap1a,
        StCap1b,
        StCap2a,
        StCap2b,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] word0_q, word0_d;
    logic [31:0] word1_q, word1_d;
    logic        expect_q, expect_d;
    logic [19:0] timer_q, timer_d;
    logic [19:0] timer_inc;
    logic [31:0] data1_q, data1_d;
    logic [31:0] data2_q, data2_d;
    logic [1:0]  status_q, status_d;
    // Holds cmd_ready low while reset is asserted; set on the first clock after release
    logic        ready_en_q;
    logic        timeout_hit;
    logic [1:0]  timeout_code;

`ifdef DYNA_RETRY_EN
    logic [2:0]  retry_q, retry_d;
`else
    logic        unused_retry_max;
    assign unused_retry_max = (RETRY_MAX != 0);
`endif

    // Timer saturates at all-ones so it can never wrap back into range
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 20'd1;

    assign cmd_ready  = (state_q == StIdle) && ready_en_q;
    assign busy       = (state_q != StIdle);
    assign rsp_valid  = (state_q == StResp);
    assign rsp_data1  = data1_q;
    assign rsp_data2  = data2_q;
    assign rsp_status = status_q;

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            word0_q    <= '0;
            word1_q    <= '0;
            expect_q   <= 1'b0;
            timer_q    <= '0;
            data1_q    <= '0;
            data2_q    <= '0;
            status_q   <= StatusOk;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word0_q    <= word0_d;
            word1_q    <= word1_d;
            expect_q   <= expect_d;
            timer_q    <= timer_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            status_q   <= status_d;
            ready_en_q <= 1'b1;
        end
    end

`ifdef DYNA_RETRY_EN
    // Retry counter for the current command
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    // Next-state, register-bus drive and response capture
    always_comb begin
        state_d        = state_q;
        word0_d        = word0_q;
        word1_d        = word1_q;
        expect_d       = expect_q;
        timer_d        = timer_q;
        data1_d        = data1_q;
        data2_d        = data2_q;
        status_d       = status_q;
        timeout_hit    = 1'b0;
        timeout_code   = StatusTxTmo;
        dyn_rw_ad      = AddrRxStat;
        dyn_write_en   = 1'b0;
        dyn_read_en    = 1'b0;
        dyn_write_data = '0;
`ifdef DYNA_RETRY_EN
        retry_d        = retry_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && ready_en_q) begin
                    word0_d  = cmd_word0;
                    word1_d  = cmd_word1;
                    expect_d = cmd_expect_reply;
`ifdef DYNA_RETRY_EN
                    retry_d  = '0;
`endif
                    state_d  = StLoad0;
                end
            end
            StLoad0: begin
                dyn_rw_ad      = AddrWord0;
                dyn_write_en   = 1'b1;
                dyn_write_data = word0_q;
                state_d        = StLoad1;
            end
            StLoad1: begin
                dyn_rw_ad      = AddrWord1;
                dyn_write_en   = 1'b1;
                dyn_write_data = word1_q;
                state_d        = StStart;
            end
            StStart: begin
                dyn_rw_ad      = AddrTxCtl;
                dyn_write_en   = 1'b1;
                dyn_write_data = 32'd1;
                timer_d        = '0;
                state_d        = StWaitTx;
            end
            StWaitTx: begin
                dyn_rw_ad   = AddrTxCtl;
                dyn_read_en = 1'b1;
                timer_d     = timer_inc;
                // Read data lags the address by a cycle, so the first cycle is stale.
                // Done is checked ahead of the timeout so it wins a same-cycle tie.
                if ((timer_q != '0) && dyn_read_data[0]) begin
                    if (expect_q) begin
                        state_d = StClr;
                    end else begin
                        status_d = StatusNoReply;
                        data1_d  = '0;
                        data2_d  = '0;
                        state_d  = StResp;
                    end
                end else if (timer_q == TimeoutLast) begin
                    timeout_hit  = 1'b1;
                    timeout_code = StatusTxTmo;
                end
            end
            StClr: begin
                dyn_rw_ad   = AddrRxStat;
                dyn_read_en = 1'b1;
                timer_d     = '0;
                state_d     = StWaitRx;
            end
            StWaitRx: begin
                dyn_rw_ad   = AddrRxStat;
                dyn_read_en = 1'b1;
                timer_d     = timer_inc;
                if ((timer_q != '0) && dyn_read_data[0]) begin
                    state_d = StCap1a;
                end else if (timer_q == TimeoutLast) begin
                    timeout_hit  = 1'b1;
                    timeout_code = StatusRxTmo;
                end
            end
            StCap1a: begin
                dyn_rw_ad   = AddrData1;
                dyn_read_en = 1'b1;
                state_d     = StCap1b;
            end
            StCap1b: begin
                dyn_rw_ad   = AddrData1;
                dyn_read_en = 1'b1;
                data1_d     = dyn_read_data;
                state_d     = StCap2a;
            end
            StCap2a: begin
                dyn_rw_ad   = AddrData2;
                dyn_read_en = 1'b1;
                state_d     = StCap2b;
            end
            StCap2b: begin
                dyn_rw_ad   = AddrData2;
                dyn_read_en = 1'b1;
                data2_d     = dyn_read_data;
                status_d    = StatusOk;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (timeout_hit) begin
`ifdef DYNA_RETRY_EN
            if (32'(retry_q) < RETRY_MAX) begin
                // Full reload: the UART may have lost the earlier programming
                retry_d = retry_q + 3'd1;
                state_d = StLoad0;
            end else begin
                status_d = timeout_code;
                data1_d  = '0;
                data2_d  = '0;
                state_d  = StResp;
            end
`else
            status_d = timeout_code;
            data1_d  = '0;
            data2_d  = '0;
            state_d  = StResp;
`endif
        end
    end

endmodule

// File: tb/tb_dyna_cmd_sequencer.sv
// Bench for dyna_cmd_sequencer: a behavioural UART_Dynamixel register model
// plus a high-level outcome model (status, reply words, number of attempts).
`timescale 1ns/1ps
module tb_dyna_cmd_sequencer;

    localparam int unsigned T      = 16;
    localparam int unsigned RMAX   = 2;
    localparam int unsigned NEVER  = 32'hFFFF_FFFF;
    localparam int unsigned BUDGET = 2000;
`ifdef DYNA_RETRY_EN
    localparam int unsigned ATTEMPTS = RMAX + 1;
`else
    localparam int unsigned ATTEMPTS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_word0;
    logic [31:0] cmd_word1;
    logic        cmd_expect_reply;
    logic [2:0]  dyn_rw_ad;
    logic        dyn_write_en;
    logic        dyn_read_en;
    logic [31:0] dyn_write_data;
    logic [31:0] dyn_read_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data1;
    logic [31:0] rsp_data2;
    logic [1:0]  rsp_status;
    logic        busy;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    dyna_cmd_sequencer #(
        .TIMEOUT_CYCLES(T),
        .RETRY_MAX     (RMAX)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_word0       (cmd_word0),
        .cmd_word1       (cmd_word1),
        .cmd_expect_reply(cmd_expect_reply),
        .dyn_rw_ad       (dyn_rw_ad),
        .dyn_write_en    (dyn_write_en),
        .dyn_read_en     (dyn_read_en),
        .dyn_write_data  (dyn_write_data),
        .dyn_read_data   (dyn_read_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data1       (rsp_data1),
        .rsp_data2       (rsp_data2),
        .rsp_status      (rsp_status),
        .busy            (busy)
    );

    // UART register model: TX/RX done rise a set number of cycles after a start write
    int unsigned m_tx_delay = NEVER;
    int unsigned m_rx_delay = NEVER;
    logic [31:0] m_data1    = 32'h0;
    logic [31:0] m_data2    = 32'h0;
    int unsigned m_cnt      = 0;
    logic        m_started  = 1'b0;
    logic [31:0] rd_q       = 32'h0;
    logic        m_tx_done;
    logic        m_rx_done;
    logic [34:0] wr_log[$];
    int unsigned rd0_cnt    = 0;
    int unsigned rdcap_cnt  = 0;
    int unsigned rdtx_cnt   = 0;

    assign m_tx_done     = m_started && (m_cnt >= m_tx_delay);
    assign m_rx_done     = m_started && (m_cnt >= m_rx_delay);
    assign dyn_read_data = rd_q;

    always @(posedge clk) begin
        if (dyn_write_en) wr_log.push_back({dyn_rw_ad, dyn_write_data});
        if (dyn_write_en && dyn_rw_ad == 3'b100 && dyn_write_data[0]) begin
            m_started <= 1'b1;
            m_cnt     <= 0;
        end else if (m_started) begin
            m_cnt <= m_cnt + 1;
        end
        if (dyn_read_en) begin
            if (dyn_rw_ad == 3'b100) begin
                rd_q     <= {31'h0, m_tx_done};
                rdtx_cnt <= rdtx_cnt + 1;
            end else if (dyn_rw_ad == 3'b000) begin
                rd_q    <= {31'h0, m_rx_done};
                rd0_cnt <= rd0_cnt + 1;
            end else if (dyn_rw_ad == 3'b001) begin
                rd_q      <= m_data1;
                rdcap_cnt <= rdcap_cnt + 1;
            end else if (dyn_rw_ad == 3'b010) begin
                rd_q      <= m_data2;
                rdcap_cnt <= rdcap_cnt + 1;
            end else begin
                rd_q <= 32'h0;
            end
        end else begin
            rd_q <= 32'h0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outcome model. TX done is read back one cycle late, so it must be raised by
    // the second-to-last WAIT_TX cycle; done and timeout together count as done.
    // RX delays used here are either NEVER or well inside the window.
    function automatic void ref_model(input logic er, input int unsigned txd,
                                      input int unsigned rxd, input logic [31:0] d1,
                                      input logic [31:0] d2, output logic [1:0] st,
                                      output logic [31:0] o1, output logic [31:0] o2,
                                      output int unsigned attempts);
        o1       = 32'h0;
        o2       = 32'h0;
        attempts = 1;
        if (txd > T - 2) begin
            st       = 2'b01;
            attempts = ATTEMPTS;
        end else if (!er) begin
            st = 2'b11;
        end else if (rxd == NEVER) begin
            st       = 2'b10;
            attempts = ATTEMPTS;
        end else begin
            st = 2'b00;
            o1 = d1;
            o2 = d2;
        end
    endfunction

    task automatic run_cmd(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                           input logic er, input int unsigned txd, input int unsigned rxd,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input int unsigned hold);
        logic [1:0]  e_st;
        logic [31:0] e_d1, e_d2;
        int unsigned e_att, lat, guard, base_wr, b_rd0, b_cap, b_tx, n_wr;
        logic        ok;
        logic [34:0] ent, want;
        ref_model(er, txd, rxd, d1, d2, e_st, e_d1, e_d2, e_att);
        m_tx_delay = txd;
        m_rx_delay = rxd;
        m_data1    = d1;
        m_data2    = d2;
        rsp_ready  = (hold == 0);
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < BUDGET) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, "/idle_ready"}, cmd_ready, 1'b1);
        base_wr = wr_log.size();
        b_rd0 = rd0_cnt; b_cap = rdcap_cnt; b_tx = rdtx_cnt;
        cmd_word0 = w0; cmd_word1 = w1; cmd_expect_reply = er; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < BUDGET) begin
            @(posedge clk); #1; lat++;
            // A command offered while busy must be ignored
            if (lat == 2) begin
                cmd_word0 = ~w0; cmd_word1 = ~w1; cmd_valid = 1'b1;
            end else if (lat == 3) begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check({tag, "/rsp_seen"}, rsp_valid, 1'b1);
        if (rsp_valid !== 1'b1) return;
        check({tag, "/status"}, rsp_status, e_st);
        check({tag, "/data"}, {rsp_data1, rsp_data2}, {e_d1, e_d2});
        if (e_st == 2'b11) check({tag, "/latency"}, lat, txd + 5);
        if (e_st == 2'b01) begin
            check({tag, "/latency"}, lat, e_att * (3 + T));
            check({tag, "/tx_polls"}, rdtx_cnt - b_tx, e_att * T);
        end
        n_wr = wr_log.size() - base_wr;
        check({tag, "/wr_count"}, n_wr, 3 * e_att);
        ok = 1'b1;
        for (int i = 0; i < int'(n_wr); i++) begin
            ent = wr_log[base_wr + i];
            if (i % 3 == 0)      want = {3'b101, w0};
            else if (i % 3 == 1) want = {3'b110, w1};
            else                 want = {3'b100, 32'd1};
            if (ent !== want) ok = 1'b0;
        end
        check({tag, "/wr_order"}, ok, 1'b1);
        check({tag, "/cap_reads"}, rdcap_cnt - b_cap, (e_st == 2'b00) ? 4 : 0);
        if (!er) check({tag, "/no_rx_reads"}, rd0_cnt - b_rd0, 0);
        for (int i = 0; i < int'(hold); i++) begin
            @(posedge clk); #1;
            check({tag, "/stall_ctl"}, {rsp_valid, cmd_ready, busy, rsp_status},
                  {3'b101, e_st});
            check({tag, "/stall_data"}, {rsp_data1, rsp_data2}, {e_d1, e_d2});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "/post_hs"}, {rsp_valid, cmd_ready, busy}, 3'b010);
    endtask

    initial begin
        int unsigned guard;
        int unsigned txd, rxd;
        reset = 1'b0; cmd_valid = 1'b0; cmd_word0 = '0; cmd_word1 = '0;
        cmd_expect_reply = 1'b0; rsp_ready = 1'b1;
        #2;
        check("reset/ctl", {cmd_ready, busy, dyn_write_en, dyn_read_en, rsp_valid,
                            dyn_rw_ad, rsp_status}, '0);
        check("reset/data", {dyn_write_data, rsp_data1}, '0);
        check("reset/data2", rsp_data2, '0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("release/ready", {cmd_ready, busy, dyn_write_en}, 3'b100);

        run_cmd("reply", 32'hCF0204FE, 32'h0000012B, 1'b1, 10, 22,
                32'h11223344, 32'h55667788, 0);
        run_cmd("noreply", 32'hA5A5_0001, 32'h0000_0102, 1'b0, 3, NEVER, 32'h1, 32'h2, 0);
        run_cmd("minlat", 32'h0000_0003, 32'h0000_0004, 1'b0, 0, NEVER, 32'h1, 32'h2, 0);
        run_cmd("tx_edge_ok", 32'h1111_0000, 32'h2222_0000, 1'b0, T - 2, NEVER, 0, 0, 0);
        run_cmd("tx_edge_tmo", 32'h3333_0000, 32'h4444_0000, 1'b0, T - 1, NEVER, 0, 0, 0);
        run_cmd("tx_never", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, NEVER, NEVER, 0, 0, 0);
        run_cmd("rx_never", 32'h0102_0304, 32'h0506_0708, 1'b1, 4, NEVER,
                32'h9, 32'h9, 20);

        for (int n = 0; n < 8; n++) begin
            txd = ($urandom_range(0, 4) == 0) ? NEVER : $urandom_range(0, 12);
            rxd = ($urandom_range(0, 3) == 0) ? NEVER :
                  ((txd == NEVER) ? 0 : txd) + $urandom_range(0, 8);
            run_cmd($sformatf("rand%0d", n), $urandom, $urandom, 1'($urandom_range(0, 1)),
                    txd, rxd, $urandom, $urandom, $urandom_range(0, 2));
        end

        // Leave non-zero reply words behind, then reset in the middle of WAIT_RX
        run_cmd("pre_rst", 32'h7777_0000, 32'h8888_0000, 1'b1, 2, 6,
                32'hCAFE_0001, 32'hCAFE_0002, 0);
        m_tx_delay = 2; m_rx_delay = NEVER;
        cmd_word0 = 32'h1234_5678; cmd_word1 = 32'h9ABC_DEF0; cmd_expect_reply = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        guard = 0;
        while (!(dyn_read_en === 1'b1 && dyn_rw_ad === 3'b000) && guard < BUDGET) begin
            @(posedge clk); #1; guard++;
        end
        check("rst/reach_wait_rx", guard < BUDGET, 1'b1);
        @(posedge clk); @(posedge clk); @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("rst/ctl", {cmd_ready, busy, dyn_write_en, dyn_read_en, rsp_valid,
                          dyn_rw_ad, rsp_status}, '0);
        check("rst/data", {rsp_data1, rsp_data2}, '0);
        check("rst/wdata", dyn_write_data, '0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst/release_ready", cmd_ready, 1'b1);
        run_cmd("post_rst", 32'hCF0204FE, 32'h0000012B, 1'b1, 5, 9,
                32'hAABB_CCDD, 32'h0011_2233, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

endmodule
